// File: rtl/main_mem_arbiter_if.sv
// Bundles the core request side and the main-memory beat side of main_mem_arbiter.
// The master modport is the arbiter; the slave modport is the cores/memory environment.
interface main_mem_arbiter_if #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [NUM_CORES-1:0]            w_req;
  logic [NUM_CORES-1:0]            w_req_rw;
  logic [NUM_CORES*ADDR_WIDTH-1:0] w_req_addr;
  logic                            w_main_mem_ready;
  logic [NUM_CORES-1:0]            w_grant;
  logic                            w_beat;
  logic [NUM_CORES-1:0]            w_done;
  logic                            w_main_mem_en;
  logic                            w_main_mem_rw;
  logic [ADDR_WIDTH-1:0]           w_main_mem_addr;

  modport master (
    input  w_req, w_req_rw, w_req_addr, w_main_mem_ready,
    output w_grant, w_beat, w_done, w_main_mem_en, w_main_mem_rw, w_main_mem_addr
  );

  modport slave (
    output w_req, w_req_rw, w_req_addr, w_main_mem_ready,
    input  w_grant, w_beat, w_done, w_main_mem_en, w_main_mem_rw, w_main_mem_addr
  );
endinterface

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter giving one core at a time a fixed-length burst on the main-memory port.
// Addresses increment per accepted beat from the latched base and wrap at 2^ADDR_WIDTH.
module main_mem_arbiter #(
  parameter int unsigned NUM_CORES         = 4,
  parameter int unsigned ADDR_WIDTH        = 16,
  parameter int unsigned BURST_WIDTH       = 4,
  parameter int unsigned FIXED_BURST_WRITE = 4,
  parameter int unsigned FIXED_BURST_READ  = 8
) (
  input  logic                 w_clock,
  input  logic                 w_reset_n,
  main_mem_arbiter_if.master   bus
);
  localparam int unsigned PtrWidth = $clog2(NUM_CORES);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e                 state_q, state_d;
  logic [PtrWidth-1:0]    rr_q, rr_d;
  logic [PtrWidth-1:0]    owner_q, owner_d;
  logic [NUM_CORES-1:0]   grant_q, grant_d;
  logic                   rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [BURST_WIDTH-1:0] len_q, len_d;
  logic [BURST_WIDTH-1:0] beat_q, beat_d;

  logic                   pick_valid;
  logic [PtrWidth-1:0]    pick_idx;
  logic                   last_beat;
  int unsigned            cand;

  // First requester at or above the rr pointer, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand = (32'(rr_q) + i) % NUM_CORES;
      if (!pick_valid && bus.w_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = PtrWidth'(cand);
      end
    end
  end

  assign last_beat = (beat_q == len_q - BURST_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    rw_d    = rw_q;
    base_d  = base_q;
    len_d   = len_q;
    beat_d  = beat_q;

    bus.w_grant         = '0;
    bus.w_beat          = 1'b0;
    bus.w_done          = '0;
    bus.w_main_mem_en   = 1'b0;
    bus.w_main_mem_rw   = 1'b0;
    bus.w_main_mem_addr = '0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StBurst;
          owner_d = pick_idx;
          grant_d = NUM_CORES'(1) << pick_idx;
          rw_d    = bus.w_req_rw[pick_idx];
          base_d  = bus.w_req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          len_d   = bus.w_req_rw[pick_idx] ? BURST_WIDTH'(FIXED_BURST_WRITE)
                                           : BURST_WIDTH'(FIXED_BURST_READ);
          beat_d  = '0;
        end
      end
      StBurst: begin
        bus.w_grant         = grant_q;
        bus.w_main_mem_en   = 1'b1;
        bus.w_main_mem_rw   = rw_q;
        bus.w_main_mem_addr = base_q + ADDR_WIDTH'(beat_q);
        bus.w_beat          = bus.w_main_mem_ready;
        if (bus.w_main_mem_ready) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            bus.w_done = grant_q;
            state_d    = StIdle;
            grant_d    = '0;
            beat_d     = '0;
            rr_d       = (owner_q == PtrWidth'(NUM_CORES - 1)) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state_q <= StIdle;
      rr_q    <= '0;
      owner_q <= '0;
      grant_q <= '0;
      rw_q    <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      rw_q    <= rw_d;
      base_q  <= base_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end
endmodule

// File: tb/tb_main_mem_arbiter.sv
// Self-checking bench for main_mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_main_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int VW = N + 1 + N + 1 + 1 + AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  main_mem_arbiter_if #(.NUM_CORES(N), .ADDR_WIDTH(AW)) bus ();

  main_mem_arbiter #(
    .NUM_CORES(N), .ADDR_WIDTH(AW), .BURST_WIDTH(4),
    .FIXED_BURST_WRITE(4), .FIXED_BURST_READ(8)
  ) dut (
    .w_clock  (clk),
    .w_reset_n(rst_n),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: who owns the port, beats still to go, next address, rr start point.
  bit             m_busy;
  int             m_owner, m_left, m_rr;
  logic           m_rw;
  logic [AW-1:0]  m_addr;

  bit             drop_on_done;
  int             obs_beats, obs_dones;
  int             owners[$];
  logic [AW-1:0]  addrs[$];
  logic [N-1:0]   prev_grant;

  function automatic logic [VW-1:0] model_expect(logic ready);
    logic [N-1:0] g, d;
    if (!m_busy) return '0;
    g = N'(1) << m_owner;
    d = (m_left == 1 && ready) ? g : '0;
    return {g, ready, d, 1'b1, m_rw, m_addr};
  endfunction

  task automatic model_advance();
    if (m_busy) begin
      if (bus.w_main_mem_ready) begin
        m_addr = m_addr + 1'b1;
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_rr   = (m_owner + 1) % N;
        end
      end
    end else if (bus.w_req != 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (bus.w_req[c]) begin
          m_busy  = 1;
          m_owner = c;
          m_rw    = bus.w_req_rw[c];
          m_addr  = bus.w_req_addr[c*AW +: AW];
          m_left  = bus.w_req_rw[c] ? 4 : 8;
          break;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_rr = 0; m_owner = 0; m_left = 0; m_rw = 0; m_addr = '0;
    prev_grant = '0;
  endtask

  task automatic clear_obs();
    obs_beats = 0; obs_dones = 0;
    owners.delete(); addrs.delete();
  endtask

  // One clock: sample mid-cycle, advance the model, then release requests of finished cores.
  task automatic step(output logic [VW-1:0] act, output logic [VW-1:0] exp);
    logic [N-1:0] done_now;
    @(negedge clk);
    exp = model_expect(bus.w_main_mem_ready);
    act = {bus.w_grant, bus.w_beat, bus.w_done, bus.w_main_mem_en, bus.w_main_mem_rw,
           bus.w_main_mem_addr};
    if (bus.w_beat) begin
      obs_beats++;
      addrs.push_back(bus.w_main_mem_addr);
    end
    if (bus.w_done != 0) obs_dones++;
    if (bus.w_grant != 0 && prev_grant == 0)
      for (int i = 0; i < N; i++) if (bus.w_grant[i]) owners.push_back(i);
    prev_grant = bus.w_grant;
    done_now   = bus.w_done;
    model_advance();
    @(posedge clk);
    #1;
    if (drop_on_done) bus.w_req = bus.w_req & ~done_now;
  endtask

  task automatic set_core(int c, logic rw, logic [AW-1:0] addr);
    bus.w_req_rw[c]            = rw;
    bus.w_req_addr[c*AW +: AW] = addr;
    bus.w_req[c]               = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.w_req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    clear_obs();
  endtask

  task automatic test_reset();
    logic [VW-1:0] act;
    bus.w_req = 4'hF; bus.w_req_rw = 4'h5; bus.w_req_addr = '1; bus.w_main_mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    act = {bus.w_grant, bus.w_beat, bus.w_done, bus.w_main_mem_en, bus.w_main_mem_rw,
           bus.w_main_mem_addr};
    checks++;
    if (act !== '0) begin errors++; $display("FAIL reset_async got %h want 0", act); end
    @(posedge clk);
    #1;
    act = {bus.w_grant, bus.w_beat, bus.w_done, bus.w_main_mem_en, bus.w_main_mem_rw,
           bus.w_main_mem_addr};
    checks++;
    if (act !== '0) begin errors++; $display("FAIL reset_held got %h want 0", act); end
    bus.w_req = '0;
    rst_n = 1'b1;
    model_reset();
    clear_obs();
  endtask

  task automatic test_single_read();
    logic [VW-1:0] a, e;
    drop_on_done = 1; bus.w_main_mem_ready = 1'b1;
    set_core(1, 1'b0, 16'h0100);
    for (int c = 0; c < 11; c++) begin
      step(a, e); checks++;
      if (a !== e) begin errors++; $display("FAIL single_read cyc %0d got %h want %h", c, a, e); end
    end
    checks++;
    if (owners.size() != 1 || owners[0] != 1) begin
      errors++; $display("FAIL single_read_owner got %0d grants want core 1", owners.size());
    end
    checks++;
    if (obs_beats != 8 || obs_dones != 1) begin
      errors++; $display("FAIL single_read_counts got %0d/%0d want 8/1", obs_beats, obs_dones);
    end
    checks++;
    if (addrs.size() != 8 || addrs[0] !== 16'h0100 || addrs[7] !== 16'h0107) begin
      errors++; $display("FAIL single_read_addr got %0d beats want 0100..0107", addrs.size());
    end
  endtask

  task automatic test_all_write();
    logic [VW-1:0] a, e;
    int want[5] = '{0, 1, 2, 3, 0};
    do_reset();
    drop_on_done = 0; bus.w_main_mem_ready = 1'b1;
    for (int i = 0; i < N; i++) set_core(i, 1'b1, AW'(i * 16'h1000));
    for (int c = 0; c < 25; c++) begin
      step(a, e); checks++;
      if (a !== e) begin errors++; $display("FAIL all_write cyc %0d got %h want %h", c, a, e); end
      if (c == 24) bus.w_req = '0;
    end
    for (int c = 0; c < 2; c++) begin
      step(a, e); checks++;
      if (a !== e) begin errors++; $display("FAIL all_write_drain got %h want %h", a, e); end
    end
    checks++;
    if (owners.size() != 5) begin
      errors++; $display("FAIL all_write_grants got %0d want 5", owners.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (owners[i] != want[i]) begin
          errors++; $display("FAIL all_write_order[%0d] got %0d want %0d", i, owners[i], want[i]);
        end
      end
    end
    checks++;
    if (obs_beats != 20 || obs_dones != 5) begin
      errors++; $display("FAIL all_write_counts got %0d/%0d want 20/5", obs_beats, obs_dones);
    end
  endtask

  task automatic test_ready_toggle();
    logic [VW-1:0] a, e;
    do_reset();
    drop_on_done = 1;
    set_core(2, 1'b0, 16'h2040);
    for (int c = 0; c < 19; c++) begin
      bus.w_main_mem_ready = (c % 2 == 1);
      step(a, e); checks++;
      if (a !== e) begin errors++; $display("FAIL ready_toggle cyc %0d got %h want %h", c, a, e); end
    end
    checks++;
    if (obs_beats != 8 || obs_dones != 1 || addrs[7] !== 16'h2047) begin
      errors++; $display("FAIL ready_toggle_counts got %0d/%0d want 8/1", obs_beats, obs_dones);
    end
  endtask

  task automatic test_addr_wrap();
    logic [VW-1:0] a, e;
    logic [AW-1:0] base, want;
    clear_obs();
    drop_on_done = 1; bus.w_main_mem_ready = 1'b1;
    base = 16'hFFFE;
    set_core(0, 1'b0, base);
    for (int c = 0; c < 10; c++) begin
      step(a, e); checks++;
      if (a !== e) begin errors++; $display("FAIL addr_wrap cyc %0d got %h want %h", c, a, e); end
    end
    checks++;
    if (addrs.size() != 8) begin
      errors++; $display("FAIL addr_wrap_beats got %0d want 8", addrs.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        want = base + AW'(k);
        checks++;
        if (addrs[k] !== want) begin
          errors++; $display("FAIL addr_wrap_beat%0d got %h want %h", k, addrs[k], want);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [VW-1:0] a, e;
    do_reset();
    drop_on_done = 1; bus.w_main_mem_ready = 1'b1;
    set_core(3, 1'b0, 16'h0300);
    for (int c = 0; c < 4; c++) begin
      step(a, e); checks++;
      if (a !== e) begin errors++; $display("FAIL mid_reset_pre cyc %0d got %h want %h", c, a, e); end
    end
    #2 rst_n = 1'b0;
    #1;
    a = {bus.w_grant, bus.w_beat, bus.w_done, bus.w_main_mem_en, bus.w_main_mem_rw,
         bus.w_main_mem_addr};
    checks++;
    if (a !== '0) begin errors++; $display("FAIL mid_reset_async got %h want 0", a); end
    model_reset();
    clear_obs();
    set_core(0, 1'b0, 16'h0010);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(a, e); checks++;
      if (a !== e) begin errors++; $display("FAIL mid_reset_post cyc %0d got %h want %h", c, a, e); end
    end
    checks++;
    if (owners.size() != 2 || owners[0] != 0 || owners[1] != 3) begin
      errors++; $display("FAIL mid_reset_order got %0d grants want core0 then core3", owners.size());
    end
    checks++;
    if (obs_dones != 2) begin
      errors++; $display("FAIL mid_reset_dones got %0d want 2", obs_dones);
    end
  endtask

  task automatic test_drop_mid_write();
    logic [VW-1:0] a, e;
    clear_obs();
    drop_on_done = 0; bus.w_main_mem_ready = 1'b1;
    set_core(1, 1'b1, 16'h0A00);
    for (int c = 0; c < 7; c++) begin
      step(a, e); checks++;
      if (a !== e) begin errors++; $display("FAIL drop_write cyc %0d got %h want %h", c, a, e); end
      if (c == 2) bus.w_req[1] = 1'b0;
    end
    checks++;
    if (obs_beats != 4 || obs_dones != 1 || addrs[3] !== 16'h0A03) begin
      errors++; $display("FAIL drop_write_counts got %0d/%0d want 4/1", obs_beats, obs_dones);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] a, e;
    clear_obs();
    drop_on_done = 1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!bus.w_req[i] && $urandom_range(0, 3) == 0)
          set_core(i, 1'($urandom_range(0, 1)), AW'($urandom));
      bus.w_main_mem_ready = ($urandom_range(0, 3) != 0);
      step(a, e); checks++;
      if (a !== e) begin errors++; $display("FAIL random cyc %0d got %h want %h", c, a, e); end
    end
    checks++;
    if (obs_dones < 10) begin
      errors++; $display("FAIL random_progress got %0d bursts want at least 10", obs_dones);
    end
  endtask

  initial begin
    bus.w_req = '0; bus.w_req_rw = '0; bus.w_req_addr = '0; bus.w_main_mem_ready = 1'b0;
    drop_on_done = 0;
    model_reset();
    clear_obs();
    test_reset();
    test_single_read();
    test_all_write();
    test_ready_toggle();
    test_addr_wrap();
    test_reset_mid_burst();
    test_drop_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
